fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer between the PC/branch logic and inst_mem. Owns the

---
 rtl/fetch_ctrl.sv | 76 +++++++
 tb/tb_fetch_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the fetch PC, the inst_mem handshake and the decode queue
// ports: clk, rst (async, active-high)
//        fetch_addr, fetch_req            -> inst_mem (registered)
//        request_data, fetch_data_valid   <- inst_mem
//        redirect_valid, redirect_pc      <- branch/jump logic
//        inst_valid, inst_data, inst_pc   -> decode (queue head), inst_ready <- decode
//        fetch_fault                      -> sticky misaligned-redirect flag
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_addr,
  output logic        fetch_req,
  input  logic [31:0] request_data,
  input  logic        fetch_data_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic [1:0] {RUN, REDIR, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n;
  logic [AW:0] count, count_n;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] q_data [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic accept, push, pop, req_n;
  assign fetch_addr = pc;
  assign inst_valid = count != '0;
  assign inst_data = q_data[rd_ptr];
  assign inst_pc = q_pc[rd_ptr];
  // a redirect discards any word accepted in the same cycle and overrides a pop
  always_comb begin
    accept = fetch_req && fetch_data_valid;
    push = accept && !redirect_valid;
    pop = inst_valid && inst_ready && !redirect_valid;
    count_n = redirect_valid ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    pc_n = redirect_valid ? {redirect_pc[31:2], 2'b00} : accept ? pc + 32'd4 : pc;
    state_n = redirect_valid ? (redirect_pc[1:0] == 2'b00 ? REDIR : FAULT)
            : state == REDIR ? RUN : state;
    // count_n never rises while a request is pending, so an un-accepted request is held
    req_n = state_n == RUN && count_n < (AW+1)'(QDEPTH);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REDIR;
      pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fetch_req <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      count <= count_n;
      rd_ptr <= redirect_valid ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= redirect_valid ? '0 : push ? wr_ptr + AW'(1) : wr_ptr;
      fetch_req <= req_n;
      fetch_fault <= redirect_valid ? redirect_pc[1:0] != 2'b00 : fetch_fault;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= request_data;
      q_pc[wr_ptr] <= pc;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl against a program-order reference model
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int QDEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] fetch_addr, request_data = '0, redirect_pc = '0, inst_data, inst_pc;
  logic fetch_req, fetch_data_valid = 1'b0, redirect_valid = 1'b0;
  logic inst_valid, inst_ready = 1'b0, fetch_fault;
  int total = 0, bad = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_pc = RESET_PC;
  logic bubble = 1'b1, m_fault = 1'b0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .request_data(request_data), .fetch_data_valid(fetch_data_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare DUT against the reference model mid-cycle and retire decoded words
  always begin
    @(negedge clk);
    #2;
    chk("fetch_req", fetch_req, !m_fault && !bubble && sb.size() < QDEPTH);
    if (fetch_req) chk("fetch_addr", fetch_addr, exp_pc);
    chk("fetch_fault", fetch_fault, m_fault);
    chk("inst_valid", inst_valid, sb.size() != 0);
    if (inst_valid && inst_ready && !redirect_valid && sb.size() != 0) begin
      chk("inst_pc", inst_pc, sb[0][63:32]);
      chk("inst_data", inst_data, sb[0][31:0]);
      void'(sb.pop_front());
    end
  end

  // one clock: drive inputs at negedge, then apply the architectural effect of the edge
  task automatic cycle(bit rdy, bit fdv, bit redir, logic [31:0] tgt);
    bit acc;
    @(negedge clk);
    inst_ready = rdy;
    fetch_data_valid = fdv;
    redirect_valid = redir;
    redirect_pc = tgt;
    request_data = (fdv && fetch_req) ? word_at(fetch_addr) : $urandom;
    acc = fetch_req && fdv;
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      exp_pc = RESET_PC;
      bubble = 1'b1;
      m_fault = 1'b0;
    end else if (redir) begin
      sb.delete();
      exp_pc = {tgt[31:2], 2'b00};
      m_fault = tgt[1:0] != 2'b00;
      bubble = !m_fault;
    end else begin
      if (acc) begin
        sb.push_back({exp_pc, word_at(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      bubble = 1'b0;
    end
  endtask

  task automatic run(int n, int pr, int pf, int pd);
    for (int i = 0; i < n; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {22'd0, 8'($urandom), 2'b00};
      if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
      cycle(pct(pr), pct(pf), pct(pd), t);
    end
  endtask

  // asserted between edges: outputs must return to reset values with no clock
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_fetch_req", fetch_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_fetch_fault", fetch_fault, 1'b0);
    chk("rst_fetch_addr", fetch_addr, RESET_PC);
    sb.delete();
    exp_pc = RESET_PC;
    bubble = 1'b1;
    m_fault = 1'b0;
    repeat (2) cycle(1, 1, 0, '0);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) cycle(0, 0, 0, '0);
    chk("reset_fetch_addr", fetch_addr, RESET_PC);
    rst = 1'b0;
    repeat (12) cycle(1, 1, 0, '0);
    repeat (6) cycle(0, 1, 0, '0);
    repeat (6) cycle(1, 1, 0, '0);
    repeat (4) cycle(0, 1, 0, '0);
    cycle(0, 1, 1, 32'h40);
    repeat (6) cycle(1, 1, 0, '0);
    cycle(1, 0, 1, 32'h10);
    cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 32'h80);
    repeat (6) cycle(1, 1, 0, '0);
    repeat (3) begin
      repeat (3) cycle(1, 0, 0, '0);
      cycle(1, 1, 0, '0);
    end
    cycle(1, 1, 1, 32'h42);
    repeat (6) run(1, 80, 80, 0);
    cycle(1, 1, 1, 32'h100);
    repeat (10) cycle(1, 1, 0, '0);
    repeat (4) cycle(0, 1, 0, '0);
    async_reset();
    repeat (6) cycle(1, 1, 0, '0);
    cycle(1, 1, 1, 32'hFFFF_FFF0);
    repeat (10) cycle(1, 1, 0, '0);
    run(2000, 70, 60, 4);
    cycle(1, 1, 1, 32'h7B);
    repeat (2) cycle(1, 1, 0, '0);
    async_reset();
    repeat (8) cycle(1, 1, 0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
